// File: rtl/config_chain_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// config_chain_loader
//
// Transmitter end of the fabric configuration shift chain. Configuration
// words arrive from the host bus over a valid/ready handshake. Each word is
// serialised LSB-first, one bit per clock, onto the chain's shift input.
// Once exactly CHAIN_LEN bits have been shifted, a set pulse commits the
// chain contents into the tiles' configuration registers.
//
// Parameters:
//   WORD_W      width of host configuration words
//   CHAIN_LEN   total number of configuration bits in the chain (>= 1)
//   SET_CYCLES  width of the commit pulse in clocks (>= 1)
//
// Ports:
//   clk         fabric clock
//   rst         asynchronous reset, active-low (0 = reset)
//   start       begin a load; only looked at while idle
//   word_data   configuration word from the host
//   word_valid  word_data is valid
//   word_ready  loader takes the offered word this cycle
//   cen         chain shift enable
//   shift_out   serial data to the chain's shift_in
//   set_out     commit pulse to the chain's set_in
//   busy        a load is in progress
//   done        one-cycle pulse at the end of a load
//   crc         (only with CONFIG_LOADER_CRC_EN) CRC-16-CCITT over every
//               bit driven with cen=1, in shift order
//
// Optional feature macro: CONFIG_LOADER_CRC_EN
//   When defined, the crc[15:0] output and its update logic are added.
//   When undefined, the port and logic are absent; everything else is the
//   same.
// ---------------------------------------------------------------------------
module config_chain_loader #(
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 1024,
    parameter int SET_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cen,
    output logic              shift_out,
    output logic              set_out,
    output logic              busy,
    output logic              done
`ifdef CONFIG_LOADER_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam int SC_W  = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CHAIN_BITS = CNT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  WORD_REST  = WB_W'(WORD_W - 1);
    localparam logic [SC_W-1:0]  SET_LAST   = SC_W'(SET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        SET,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   word_bits;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SC_W-1:0]   set_cnt;

`ifdef CONFIG_LOADER_CRC_EN
    // One step of CRC-16-CCITT (poly 0x1021), register updated MSB-first
    // with one serial input bit.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // Loader state machine. Every output is a flop written here, so the
    // cen/shift_out pair seen by the chain always comes from the same edge.
    //
    // The first bit of a word is presented on the same edge that accepts
    // the word. shreg therefore holds only the bits not yet presented, and
    // word_bits counts those remaining bits. bit_cnt counts bits already
    // presented, so a SHIFT cycle with bit_cnt == CHAIN_LEN is the last
    // chain bit; any bits left in shreg at that point are dropped.
    //
    // word_ready is only raised in FETCH, never during SHIFT, so a cen=1
    // cycle always carries a real data bit. Going back to FETCH drops cen,
    // and the chain holds its contents until the host offers the next word.
    //
    // cen is dropped on the edge that enters SET, so cen and set_out are
    // never high together; the chain gates its shift with ~set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            word_bits  <= '0;
            bit_cnt    <= '0;
            set_cnt    <= '0;
            word_ready <= 1'b0;
            cen        <= 1'b0;
            shift_out  <= 1'b0;
            set_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc        <= 16'hFFFF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        bit_cnt    <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                        crc        <= 16'hFFFF;
`endif
                    end
                end

                FETCH: begin
                    if (word_valid && word_ready) begin
                        state      <= SHIFT;
                        word_ready <= 1'b0;
                        cen        <= 1'b1;
                        shift_out  <= word_data[0];
                        shreg      <= word_data >> 1;
                        word_bits  <= WORD_REST;
                        bit_cnt    <= bit_cnt + CNT_W'(1);
`ifdef CONFIG_LOADER_CRC_EN
                        crc        <= crc_step(crc, word_data[0]);
`endif
                    end
                end

                SHIFT: begin
                    if (bit_cnt == CHAIN_BITS) begin
                        state     <= SET;
                        cen       <= 1'b0;
                        shift_out <= 1'b0;
                        set_out   <= 1'b1;
                        set_cnt   <= '0;
                    end else if (word_bits == '0) begin
                        state      <= FETCH;
                        cen        <= 1'b0;
                        shift_out  <= 1'b0;
                        word_ready <= 1'b1;
                    end else begin
                        shift_out <= shreg[0];
                        shreg     <= shreg >> 1;
                        word_bits <= word_bits - WB_W'(1);
                        bit_cnt   <= bit_cnt + CNT_W'(1);
`ifdef CONFIG_LOADER_CRC_EN
                        crc       <= crc_step(crc, shreg[0]);
`endif
                    end
                end

                SET: begin
                    if (set_cnt == SET_LAST) begin
                        state   <= DONE;
                        set_out <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        set_cnt <= set_cnt + SC_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    word_ready <= 1'b0;
                    cen        <= 1'b0;
                    shift_out  <= 1'b0;
                    set_out    <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_config_chain_loader
//
// Two loaders are instantiated:
//   dut  : WORD_W=32, CHAIN_LEN=40, SET_CYCLES=1, followed cycle by cycle
//          by a queue-based reference model.
//   dut8 : WORD_W=32, CHAIN_LEN=8,  SET_CYCLES=3, checked against
//          hand-computed expectations (long set pulse, short chain, CRC).
// ---------------------------------------------------------------------------
module tb_config_chain_loader;

    localparam int WORD_W     = 32;
    localparam int CHAIN_LEN  = 40;
    localparam int SET_CYCLES = 1;
    localparam int LEN8       = 8;
    localparam int SET8       = 3;

    logic        clk;
    logic        rst;

    logic        start;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready, cen, shift_out, set_out, busy, done;

    logic        start8;
    logic [31:0] word_data8;
    logic        word_valid8;
    logic        word_ready8, cen8, shift_out8, set_out8, busy8, done8;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc, crc8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .SET_CYCLES(SET_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cen        (cen),
        .shift_out  (shift_out),
        .set_out    (set_out),
        .busy       (busy),
        .done       (done)
`ifdef CONFIG_LOADER_CRC_EN
        ,
        .crc        (crc)
`endif
    );

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN8), .SET_CYCLES(SET8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .word_data  (word_data8),
        .word_valid (word_valid8),
        .word_ready (word_ready8),
        .cen        (cen8),
        .shift_out  (shift_out8),
        .set_out    (set_out8),
        .busy       (busy8),
        .done       (done8)
`ifdef CONFIG_LOADER_CRC_EN
        ,
        .crc        (crc8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s at %0t: got timeout, expected event", name, $time);
    endtask

`ifdef CONFIG_LOADER_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = c << 1;
        if (c[15] != b) r = r ^ 16'h1021;
        return r;
    endfunction
`endif

    // Reference model for dut: the chain must see, on consecutive cen
    // cycles, the bits of each accepted word LSB-first, cut off at
    // CHAIN_LEN bits in total. When nothing is pending and the chain is not
    // yet full, the loader must be asking for a word. Once full: SET_CYCLES
    // cycles of set, one cycle of done, then idle.
    bit  m_q[$];
    bit  m_active    = 0;
    bit  m_start_pend = 0;
    bit  m_done_seen = 0;
    int  m_sent      = 0;
    int  m_setc      = 0;
    logic [15:0] m_crc = 16'hFFFF;
    bit  e_ready, e_cen, e_set, e_done, e_busy, e_bit, e_check_bit;
    int  n_take;

    always @(negedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_active     = 0;
            m_start_pend = 0;
            m_done_seen  = 0;
            m_sent       = 0;
            m_setc       = 0;
            m_crc        = 16'hFFFF;
        end else begin
            if (!m_active && m_start_pend) begin
                m_active    = 1;
                m_sent      = 0;
                m_setc      = 0;
                m_done_seen = 0;
                m_q.delete();
                m_crc       = 16'hFFFF;
            end
            m_start_pend = 0;
            e_ready = 0; e_cen = 0; e_set = 0; e_done = 0; e_busy = 0;
            e_bit = 0; e_check_bit = 0;
            if (m_active) begin
                e_busy = 1;
                if (m_q.size() > 0) begin
                    e_cen = 1;
                    e_bit = m_q.pop_front();
                    e_check_bit = 1;
                    m_sent++;
`ifdef CONFIG_LOADER_CRC_EN
                    m_crc = crc_ref(m_crc, e_bit);
`endif
                end else if (m_sent < CHAIN_LEN) begin
                    e_ready = 1;
                end else if (m_setc < SET_CYCLES) begin
                    e_set = 1;
                    m_setc++;
                end else if (!m_done_seen) begin
                    e_done = 1;
                    m_done_seen = 1;
                end else begin
                    e_busy = 0;
                    m_active = 0;
                end
            end
            checkOutput("busy", busy, e_busy);
            checkOutput("word_ready", word_ready, e_ready);
            checkOutput("cen", cen, e_cen);
            checkOutput("set_out", set_out, e_set);
            checkOutput("done", done, e_done);
            if (e_check_bit) checkOutput("shift_out", shift_out, e_bit);
`ifdef CONFIG_LOADER_CRC_EN
            checkOutput("crc", crc, m_crc);
`endif
            if (e_ready && word_valid) begin
                n_take = WORD_W;
                if (CHAIN_LEN - m_sent < n_take) n_take = CHAIN_LEN - m_sent;
                for (int i = 0; i < n_take; i++) m_q.push_back(word_data[i]);
            end
            if (!m_active && start) m_start_pend = 1;
        end
    end

    // Observation counters used by the directed checks.
    int tr_cen, tr_set, tr_done, tr_both, tr_rdy;
    logic [63:0] tr_bits;
    int tr8_cen, tr8_ones, tr8_set, tr8_run, tr8_maxrun, tr8_done, tr8_both, tr8_acc, tr8_done_after_set;
    logic [15:0] tr8_bits;
    bit tr8_prev_set;

    always @(negedge clk) begin
        if (rst) begin
            if (cen) begin
                if (tr_cen < 64) tr_bits[tr_cen] = shift_out;
                tr_cen++;
            end
            if (set_out) tr_set++;
            if (done) tr_done++;
            if (cen && set_out) tr_both++;
            if (word_ready) tr_rdy++;

            if (cen8) begin
                if (tr8_cen < 16) tr8_bits[tr8_cen] = shift_out8;
                if (shift_out8) tr8_ones++;
                tr8_cen++;
            end
            if (set_out8) begin
                tr8_set++;
                tr8_run++;
                if (tr8_run > tr8_maxrun) tr8_maxrun = tr8_run;
            end else begin
                tr8_run = 0;
            end
            if (done8) begin
                tr8_done++;
                if (tr8_prev_set) tr8_done_after_set++;
            end
            if (cen8 && set_out8) tr8_both++;
            if (word_ready8 && word_valid8) tr8_acc++;
            tr8_prev_set = set_out8;
        end
    end

    task automatic clearTrace();
        tr_cen = 0; tr_set = 0; tr_done = 0; tr_both = 0; tr_rdy = 0; tr_bits = '0;
        tr8_cen = 0; tr8_ones = 0; tr8_set = 0; tr8_run = 0; tr8_maxrun = 0;
        tr8_done = 0; tr8_both = 0; tr8_acc = 0; tr8_done_after_set = 0;
        tr8_bits = '0; tr8_prev_set = 0;
    endtask

    // Waits until the selected loader has pulsed done and gone idle again.
    task automatic waitIdle(input bit which, input string tag);
        bit seen_done;
        bit ok;
        seen_done = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which ? done8 : done) == 1'b1) seen_done = 1;
            else if (seen_done && !(which ? busy8 : busy)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) reportTimeout(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers one word to dut. With hold_off > 0 the word is withheld for
    // that many edges after the loader starts asking for it.
    task automatic offerWord(input logic [31:0] w, input int hold_off);
        bit ok;
        word_valid = 1'b0;
        if (hold_off > 0) begin
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (word_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) reportTimeout("fetch_wait");
            repeat (hold_off) @(posedge clk);
            #1;
        end
        word_data  = w;
        word_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (word_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) reportTimeout("accept_wait");
        @(posedge clk);
        #1;
        word_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input int hold1, input string tag);
        clearTrace();
        startLoad();
        offerWord(w0, 0);
        offerWord(w1, hold1);
        waitIdle(0, tag);
    endtask

    task automatic load8(input logic [31:0] w);
        clearTrace();
        word_data8  = w;
        word_valid8 = 1'b1;
        start8      = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        waitIdle(1, "dut8_load");
        word_valid8 = 1'b0;
    endtask

    initial begin
        bit ok;
        int k;
        logic [31:0] rw0, rw1;
`ifdef CONFIG_LOADER_CRC_EN
        logic [15:0] c_exp;
`endif
        rst = 1'b0;
        start = 1'b0; word_data = '0; word_valid = 1'b0;
        start8 = 1'b0; word_data8 = '0; word_valid8 = 1'b0;
        clearTrace();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_word_ready", word_ready, 0);
        checkOutput("rst_cen", cen, 0);
        checkOutput("rst_shift_out", shift_out, 0);
        checkOutput("rst_set_out", set_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy8", busy8, 0);
`ifdef CONFIG_LOADER_CRC_EN
        checkOutput("rst_crc", crc, 16'hFFFF);
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Word-boundary load
        applyStimulus(32'hA5A50F0F, 32'h000000C3, 0, "load_boundary");
        checkOutput("boundary_cen_count", tr_cen, 40);
        checkOutput("boundary_bits", tr_bits, 64'h00C3A5A50F0F);
        checkOutput("boundary_set_count", tr_set, 1);
        checkOutput("boundary_done_count", tr_done, 1);
        checkOutput("boundary_cen_with_set", tr_both, 0);
        checkOutput("boundary_fetch_cycles", tr_rdy, 2);

        // Backpressure: second word withheld for 5 edges
        applyStimulus(32'hA5A50F0F, 32'h000000C3, 5, "load_backpressure");
        checkOutput("bp_cen_count", tr_cen, 40);
        checkOutput("bp_bits", tr_bits, 64'h00C3A5A50F0F);
        checkOutput("bp_fetch_cycles", tr_rdy, 7);
        checkOutput("bp_set_count", tr_set, 1);

        // Reset in the middle of shifting
        clearTrace();
        startLoad();
        word_data  = 32'hA5A50F0F;
        word_valid = 1'b1;
        ok = 0;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cen) k++;
            if (k >= 20) begin
                ok = 1;
                break;
            end
        end
        if (!ok) reportTimeout("midshift_wait");
        checkOutput("midshift_cen_before_reset", cen, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midshift_rst_cen", cen, 0);
        checkOutput("midshift_rst_busy", busy, 0);
        checkOutput("midshift_rst_ready", word_ready, 0);
        checkOutput("midshift_rst_set", set_out, 0);
        checkOutput("midshift_rst_done", done, 0);
        checkOutput("midshift_rst_shift_out", shift_out, 0);
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midshift_no_set", tr_set, 0);
        checkOutput("midshift_no_done", tr_done, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'hA5A50F0F, 32'h000000C3, 0, "load_after_reset");
        checkOutput("after_reset_cen_count", tr_cen, 40);
        checkOutput("after_reset_bits", tr_bits, 64'h00C3A5A50F0F);
        checkOutput("after_reset_set_count", tr_set, 1);

        // Ignored inputs: word_valid while idle, start held into SHIFT
        clearTrace();
        word_data  = 32'h12345678;
        word_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("idle_word_ready", word_ready, 0);
            checkOutput("idle_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(0, "load_ignored");
        word_valid = 1'b0;
        checkOutput("ignored_cen_count", tr_cen, 40);
        checkOutput("ignored_bits", tr_bits, 64'h007812345678);
        checkOutput("ignored_fetch_cycles", tr_rdy, 2);
        checkOutput("ignored_set_count", tr_set, 1);

        // Randomised loads checked by the reference model
        for (int n = 0; n < 20; n++) begin
            rw0 = $urandom;
            rw1 = $urandom;
            applyStimulus(rw0, rw1, int'($urandom_range(0, 4)), "load_random");
            checkOutput("random_cen_count", tr_cen, 40);
            checkOutput("random_bits", tr_bits, {24'h0, rw1[7:0], rw0});
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                word_valid = 1'($urandom_range(0, 1));
                word_data  = $urandom;
                @(posedge clk);
                #1;
            end
            word_valid = 1'b0;
        end

        // Short chain with a 3-cycle set pulse
        load8(32'h000000FF);
        checkOutput("d8_cen_count", tr8_cen, 8);
        checkOutput("d8_ones", tr8_ones, 8);
        checkOutput("d8_set_count", tr8_set, 3);
        checkOutput("d8_set_run", tr8_maxrun, 3);
        checkOutput("d8_cen_with_set", tr8_both, 0);
        checkOutput("d8_done_count", tr8_done, 1);
        checkOutput("d8_done_after_set", tr8_done_after_set, 1);
        checkOutput("d8_single_fetch", tr8_acc, 1);
        checkOutput("d8_idle_busy", busy8, 0);

        // Bit order of 0x31 on the short chain, and its CRC
        load8(32'h00000031);
        checkOutput("d8_bits_31", tr8_bits, 16'h0031);
        checkOutput("d8_cen_count_31", tr8_cen, 8);
`ifdef CONFIG_LOADER_CRC_EN
        checkOutput("d8_crc_31", crc8, 16'hB1F4);
        c_exp = 16'hFFFF;
        for (int i = 0; i < 8; i++) c_exp = crc_ref(c_exp, tr8_bits[i]);
        checkOutput("d8_crc_31_model", crc8, c_exp);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("d8_crc_31_stable", crc8, 16'hB1F4);
        load8(32'h000000FF);
        c_exp = 16'hFFFF;
        for (int i = 0; i < 8; i++) c_exp = crc_ref(c_exp, 1'b1);
        checkOutput("d8_crc_ff_model", crc8, c_exp);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Drives the configuration shift chain of tiles and connection blocks. It is the transmitter end of the chain interface: it produces the tile-side `cen`, `shift_in` and `set_in` signals.
- Accepts configuration words from the host bus through a valid/ready handshake and serializes them LSB-first, one bit per cycle.
- After exactly CHAIN_LEN bits it issues a set pulse, which commits the shifted bits into the chain's configuration registers.
- Sits between the host bus interface and the first element of the fabric's chain.

Parameters:
- WORD_W, 32, width of input configuration words.
- CHAIN_LEN, 1024, total configuration bits in the chain (>=1).
- SET_CYCLES, 1, width of the set pulse in clocks (>=1).

Ports:
- clk  input  1  fabric clock.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- start  input  1  begin a load; sampled only in IDLE.
- word_data  input  WORD_W  configuration word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle.
- cen  output  1  chain shift enable.
- shift_out  output  1  serial data to chain shift_in.
- set_out  output  1  commit pulse to chain set_in.
- busy  output  1  load in progress (not IDLE).
- done  output  1  one-cycle pulse when load completes.

Behaviour:
- Reset (rst=0, asynchronous) forces every output and register to 0 and the state to IDLE.
  - Outputs: word_ready=0, cen=0, shift_out=0, set_out=0, busy=0, done=0.
  - Bit counter is cleared.
  - Any in-progress load is abandoned. No set pulse is issued, so the chain's committed configuration is unchanged.
- States: IDLE, FETCH, SHIFT, SET, DONE.
- IDLE: start=1 moves to FETCH and clears bit_cnt (width $clog2(CHAIN_LEN+1)).
- FETCH:
  - word_ready=1.
  - On word_valid & word_ready, latch word_data into the shift register, load word_bits=WORD_W, and go to SHIFT.
  - While no word is offered, stay in FETCH with cen=0; the chain holds.
- SHIFT, each cycle:
  - cen=1 and shift_out = shreg[0].
  - shreg shifts right by one; word_bits and bit_cnt are updated.
  - When bit_cnt reaches CHAIN_LEN: go to SET. Remaining bits of the current word are discarded.
  - Otherwise, when word_bits reaches 0: go to FETCH.
  - word_ready=0 throughout SHIFT (no prefetch), so every cen=1 cycle carries valid data.
  - The first shifted bit ends up at the far end of the chain.
- SET:
  - set_out=1 for SET_CYCLES cycles; cen=0 throughout.
  - cen and set_out are never both 1, because the chain gates shift with ~set.
  - Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- word_valid in IDLE is ignored (word_ready=0).
- CHAIN_LEN not a multiple of WORD_W: the last word is partially consumed.
- CHAIN_LEN < WORD_W: a single word is fetched.
- All outputs are registered: the cen/shift_out pair is presented in the same cycle, directly from flops.

Optional Feature:
- Macro: CONFIG_LOADER_CRC_EN.
- Defined:
  - Adds output port crc [15:0], a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register update) over every bit driven with cen=1, in shift order.
  - crc is reinitialised on IDLE->FETCH and is stable from SET until the next start.
  - Reset value is 0xFFFF.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Word-boundary load. Setup: CHAIN_LEN=40, WORD_W=32, SET_CYCLES=1. Stimulus: start; words 0xA5A50F0F then 0x000000C3, valid held.
  - First 32 cen cycles: shift_out is 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1.
  - Next 8 cen cycles: 1,1,0,0,0,0,1,1.
  - Exactly 40 cen cycles, then set_out=1 for 1 cycle with cen=0, then done=1 for 1 cycle; busy falls after.
- Backpressure. Same load with word_valid deasserted for 5 cycles between the two words -> cen=0 for those cycles; the bit sequence is unchanged; total cen cycles = 40.
- Reset mid-shift. rst=0 after 20 cen cycles -> all outputs 0 immediately (asynchronous); set_out never pulses. After rst=1, start and a full load complete normally.
- Ignored inputs. start asserted during SHIFT and word_valid=1 in IDLE -> no state change, word_ready stays 0, cen count unaffected.
- Longer set pulse. SET_CYCLES=3, CHAIN_LEN=8, word 0x000000FF -> 8 cen cycles of shift_out=1, then set_out=1 for 3 cycles with cen=0 throughout, then done.
- CRC (CONFIG_LOADER_CRC_EN). CHAIN_LEN=8, word 0x00000031, so the bit order 1,0,0,0,1,1,0,0 is shifted -> after SET, crc matches the CRC-16-CCITT reference model over those 8 bits, and is stable until the next start.
